// File: rtl/jk_bank_ctrl_if.sv
// Requester / JK-bank bundle shared between the bank controller and its clients.
interface jk_bank_ctrl_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     op;
    logic [WIDTH*N_REQ-1:0] mask;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       j;
    logic [WIDTH-1:0]       k;
    logic [N_REQ-1:0]       gnt;
    logic                   ack;
    logic                   err;
    logic                   busy;

    modport master (output req, op, mask, q, input j, k, gnt, ack, err, busy);
    modport slave  (input req, op, mask, q, output j, k, gnt, ack, err, busy);
endinterface

// File: rtl/jk_bank_ctrl.sv
// Round-robin arbiter that applies one requester's hold/clear/set/toggle command
// to an external JK flop bank and verifies the readback.
module jk_bank_ctrl #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    jk_bank_ctrl_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [N_REQ-1:0] r_gnt;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_exp;
    logic             r_ack;
    logic             r_busy;

    logic [PW-1:0]    w_win;
    logic             w_any;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_val;
    logic [WIDTH-1:0] w_exp;

    // First active requester at or above r_ptr, wrapping past N_REQ-1.
    always_comb begin
        int idx;
        w_win = '0;
        w_any = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!w_any && bus.req[idx]) begin
                w_any = 1'b1;
                w_win = PW'(idx);
            end
        end
    end

    assign w_op   = bus.op[int'(w_win)*2 +: 2];
    assign w_mask = bus.mask[int'(w_win)*WIDTH +: WIDTH];

    always_comb begin
        case (w_op)
            2'b01:   w_val = '0;
            2'b10:   w_val = '1;
            2'b11:   w_val = ~bus.q;
            default: w_val = bus.q;
        endcase
    end

    assign w_exp = (bus.q & ~w_mask) | (w_val & w_mask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_exp   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= APPLY;
                        r_gnt   <= N_REQ'(1) << w_win;
                        r_ptr   <= (w_win == PW'(N_REQ-1)) ? '0 : w_win + PW'(1);
                        r_j     <= w_mask & {WIDTH{w_op[1]}};
                        r_k     <= w_mask & {WIDTH{w_op[0]}};
                        r_exp   <= w_exp;
                        r_busy  <= 1'b1;
                    end
                end
                APPLY: begin
                    r_state <= CHECK;
                    r_j     <= '0;
                    r_k     <= '0;
                    r_ack   <= 1'b1;
                end
                CHECK: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.j    = r_j;
    assign bus.k    = r_k;
    assign bus.gnt  = r_gnt;
    assign bus.ack  = r_ack;
    assign bus.busy = r_busy;
    // The bank only shows the new value after the APPLY edge, so err compares live readback in CHECK.
    assign bus.err  = (r_state == CHECK) && (bus.q != r_exp);
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl driving a behavioural JK bank.
module tb_jk_bank_ctrl;
    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        logic [N-1:0] gnt;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic [W-1:0] qa;
        logic         err;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jk_bank_ctrl_if #(.N_REQ(N), .WIDTH(W)) bus();
    jk_bank_ctrl #(.N_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    logic [W-1:0] bank;
    logic         st_en;
    logic [W-1:0] st_m;
    logic [W-1:0] st_v;

    always @(posedge clk or negedge rst) begin
        if (!rst) bank <= '0;
        else      bank <= (bank & ~(bus.j | bus.k)) | (bus.j & ~bus.k) | (bus.j & bus.k & ~bank);
    end
    assign bus.q = st_en ? ((bank & ~st_m) | (st_v & st_m)) : bank;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   m_ptr = 0;
    int   m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: predicts each command from the inputs seen before an idle edge.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            m_ptr = 0;
            m_cnt = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if (bus.req != '0) begin
            int w;
            int idx;
            exp_t it;
            logic [1:0] o;
            logic [W-1:0] mk;
            logic [W-1:0] e;
            w = -1;
            for (int n = 0; n < N; n++) begin
                idx = (m_ptr + n) % N;
                if (w < 0 && bus.req[idx]) w = idx;
            end
            o  = bus.op[2*w +: 2];
            mk = bus.mask[W*w +: W];
            for (int b = 0; b < W; b++) begin
                if (!mk[b])          e[b] = bus.q[b];
                else if (o == 2'd0)  e[b] = bus.q[b];
                else if (o == 2'd1)  e[b] = 1'b0;
                else if (o == 2'd2)  e[b] = 1'b1;
                else                 e[b] = ~bus.q[b];
                it.j[b] = mk[b] && (o == 2'd2 || o == 2'd3);
                it.k[b] = mk[b] && (o == 2'd1 || o == 2'd3);
            end
            it.qa  = st_en ? ((e & ~st_m) | (st_v & st_m)) : e;
            it.err = (it.qa != e);
            it.gnt = N'(1) << w;
            it.cyc = cyc;
            sb.push_back(it);
            m_ptr = (w + 1) % N;
            m_cnt = 2;
        end
    end

    logic [N-1:0] p_gnt;
    logic [W-1:0] p_j;
    logic [W-1:0] p_k;

    // Monitor: pops one expectation per ack and checks the APPLY cycle just before it.
    always @(negedge clk) begin
        exp_t it;
        if (rst) begin
            chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
            if (bus.ack) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 1, 0);
                end else begin
                    it = sb.pop_front();
                    chk("apply_gnt", p_gnt, it.gnt);
                    chk("apply_j", p_j, it.j);
                    chk("apply_k", p_k, it.k);
                    chk("check_gnt", bus.gnt, it.gnt);
                    chk("check_jk", {bus.j, bus.k}, 0);
                    chk("check_err", bus.err, it.err);
                    chk("check_q", bus.q, it.qa);
                    chk("check_busy", bus.busy, 1);
                    chk("ack_latency", cyc, it.cyc + 2);
                end
            end
        end
        p_gnt = bus.gnt;
        p_j   = bus.j;
        p_k   = bus.k;
    end

    task automatic wait_ack(output logic [N-1:0] g, output logic e);
        logic got;
        got = 1'b0;
        g = '0;
        e = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(posedge clk); #1;
            if (bus.ack) begin
                got = 1'b1;
                g = bus.gnt;
                e = bus.err;
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    task automatic cmd(input int r, input logic [1:0] o, input logic [W-1:0] m,
                       output logic [N-1:0] g, output logic e);
        @(posedge clk); #1;
        bus.op[2*r +: 2]   = o;
        bus.mask[W*r +: W] = m;
        bus.req = N'(1) << r;
        wait_ack(g, e);
        bus.req = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] g;
        logic         e;
        logic [N-1:0] gseq [5];
        int           acyc [5];
        logic [N-1:0] exp_seq [5];
        logic         found;
        bus.req = '0; bus.op = '0; bus.mask = '0;
        st_en = 1'b0; st_m = '0; st_v = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_jk", {bus.j, bus.k}, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b1;

        cmd(0, 2'b10, 8'h0F, g, e);
        chk("set_gnt", g, 4'b0001);
        chk("set_err", e, 0);
        @(posedge clk); #1;
        chk("set_q", bus.q, 8'h0F);

        cmd(1, 2'b11, 8'hFF, g, e);
        chk("tog_gnt", g, 4'b0010);
        chk("tog_err", e, 0);
        @(posedge clk); #1;
        chk("tog_q", bus.q, 8'hF0);

        cmd(2, 2'b01, 8'hFF, g, e);
        cmd(3, 2'b10, 8'h01, g, e);
        chk("prep_q", bus.q, 8'h01);

        // All requesters held: grants must rotate starting from requester 0.
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        @(posedge clk); #1;
        bus.op  = '0;
        bus.req = '1;
        for (int a = 0; a < 5; a++) begin
            wait_ack(g, e);
            gseq[a] = g;
            acyc[a] = cyc;
        end
        bus.req = '0;
        for (int a = 0; a < 5; a++) begin
            chk($sformatf("rr_gnt%0d", a), gseq[a], exp_seq[a]);
            if (a > 0) chk($sformatf("rr_gap%0d", a), acyc[a] - acyc[a-1], 3);
        end

        st_en = 1'b1; st_m = 8'h01; st_v = 8'h01;
        cmd(0, 2'b01, 8'h01, g, e);
        chk("stuck_err", e, 1);
        @(posedge clk); #1;
        chk("stuck_err_clr", bus.err, 0);
        st_en = 1'b0;

        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (bus.ack) bus.req = bus.req & ~bus.gnt;
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] && $urandom_range(3) == 0) begin
                    bus.op[2*i +: 2]   = 2'($urandom_range(3));
                    bus.mask[W*i +: W] = W'($urandom);
                    bus.req[i] = 1'b1;
                end
            end
        end
        bus.req = '0;
        repeat (10) @(posedge clk);
        #1;
        chk("drain", sb.size(), 0);

        // Reset during APPLY drops the command; arbitration restarts at requester 0.
        bus.req = 4'b0100;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(posedge clk); #1;
            if (bus.gnt != '0) found = 1'b1;
        end
        chk("pre_rst_grant", found, 1);
        rst = 1'b0;
        #1;
        chk("arst_jk", {bus.j, bus.k}, 0);
        chk("arst_gnt", bus.gnt, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_ack", bus.ack, 0);
        bus.req = 4'b1000;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_no_ack", bus.ack, 0);
        end
        bus.req = 4'b1001;
        rst = 1'b1;
        wait_ack(g, e);
        bus.req = '0;
        chk("post_rst_gnt", g, 4'b0001);

        repeat (5) @(posedge clk);
        #1;
        chk("final_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jk_bank_ctrl.md
JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the JK flip-flop bank (2..8).
REQ-002 Parameter WIDTH, default 8, number of JK flip-flops in the shared bank.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 req  input  N_REQ  per-requester request; held high until the matching ack.
REQ-006 op  input  2*N_REQ  per-requester command, bits [2i+1:2i]: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-007 mask  input  WIDTH*N_REQ  per-requester bit select, bits [WIDTH*i+WIDTH-1:WIDTH*i]; 1 = command applies to that flop.
REQ-008 q  input  WIDTH  Q readback from the external JK bank.
REQ-009 j  output  WIDTH  J drive to the bank, registered.
REQ-010 k  output  WIDTH  K drive to the bank, registered.
REQ-011 gnt  output  N_REQ  one-hot grant, registered; high for the whole command.
REQ-012 ack  output  1  one-cycle pulse at command completion.
REQ-013 err  output  1  valid with ack: 1 = readback mismatch.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, APPLY, CHECK. Transitions: IDLE->APPLY when any req bit is high; APPLY->CHECK unconditionally; CHECK->IDLE unconditionally.
REQ-016 IDLE: winner = first requester with req high, searching upward from rr_ptr with wrap-around from N_REQ-1 to 0.
REQ-017 On the IDLE->APPLY edge, the block registers: gnt = one-hot winner; the winner's op and mask; rr_ptr = (winner+1) mod N_REQ.
REQ-018 APPLY (exactly one cycle): per bit b with mask=1, drive j/k: hold 0/0, clear 0/1, set 1/0, toggle 1/1. Bits with mask=0 drive j=k=0.
REQ-019 On entry to APPLY, the block registers expected: masked bits take 0 (clear), 1 (set), ~q[b] (toggle) or q[b] (hold), using q sampled on the IDLE->APPLY edge; unmasked bits take q[b].
REQ-020 CHECK: j=k=0; ack=1 for one cycle; err = (q != expected); gnt stays asserted; busy=1.
REQ-021 On CHECK->IDLE, gnt clears to 0 and err clears to 0.
REQ-022 Command latency: req sampled high in IDLE at edge n -> j/k valid during cycle n+1 -> ack during cycle n+2; the next grant is no earlier than edge n+3.
REQ-023 A req deasserted after grant does not abort the command; it completes and acks normally.
REQ-024 A req still high in the IDLE cycle after its ack is a new request; round-robin order still applies.
REQ-025 Changes to req/op/mask during APPLY or CHECK have no effect on the command in flight.
REQ-026 All requesters high continuously -> grants rotate 0,1,...,N_REQ-1,0; no requester is granted twice while another waits.
REQ-027 gnt is never multi-hot; j and k are both 0 outside APPLY.

Reset
REQ-028 rst low asynchronously forces: state IDLE, rr_ptr=0, gnt=0, j=0, k=0, ack=0, err=0, busy=0, expected=0. This holds in any state, including APPLY and CHECK.
REQ-029 A command interrupted by reset is dropped with no ack. After rst rises, the first arbitration starts from requester 0.

Verification
REQ-030 Bench connects WIDTH JK flip-flops (reset clears Q) to j/k/q and drives N_REQ=4, WIDTH=8.
REQ-031 Reset, then req=0001, op0=10, mask0=0x0F -> gnt=0001 next cycle; j=0x0F, k=0x00 in APPLY; ack with err=0; q=0x0F.
REQ-032 From q=0x0F: req=0010, op1=11, mask1=0xFF -> j=k=0xFF in APPLY; ack err=0; q=0xF0.
REQ-033 req=1111 held continuously, all ops hold -> gnt sequence 0001,0010,0100,1000,0001; ack every 3 cycles.
REQ-034 Bench forces one q bit stuck during a clear of mask 0x01 from q=0x01 -> ack with err=1; err=0 the following cycle.
REQ-035 rst pulsed low during APPLY -> j=k=gnt=busy=0 immediately, no ack; req=1000 then req=1001 after release -> requester 0 is granted first.
